step_sequencer: RTL and testbench
=================================

Name: step_sequencer

Overview:
- 8-step note sequencer that sits directly upstream of the synth top.
- Drives the synth's trig and osc_count inputs from a programmable pattern, on the 20.48 MHz system clock.
- Timing is in "ticks" of TICK_DIV clocks; default tick = one ADSR clock period (78.125 Hz). This guarantees trig high/low phases survive the synth's two-stage ADSR-clock synchronizer.

Parameters:
- TICK_DIV, 262144: system clocks per tick; must be ≥ 2.
- STEPS, 8: pattern length capacity.

Ports:
- clk  in  1  20.48 MHz system clock
- rst  in  1  asynchronous reset, active-high
- run  in  1  level; high = play, low = stop
- wr_en  in  1  pattern write strobe, one cycle
- wr_addr  in  3  step index to write
- wr_data  in  13  bit 12 = gate enable, bits 11:0 = osc_count value
- last_step  in  3  final step index before wrap
- step_ticks  in  8  step duration in ticks
- gate_ticks  in  8  trig high duration in ticks
- osc_count  out  12  to synth osc_count
- trig  out  1  to synth trig
- step_idx  out  3  current step
- step_stb  out  1  one-cycle pulse at each step start

Behaviour:
- Reset values:
  - osc_count=0, trig=0, step_idx=0, step_stb=0, FSM=IDLE, prescaler=0.
  - Pattern memory cleared to 0 (gate off, count 0).
- Pattern memory:
  - STEPS × 13 bits, written on the clk edge when wr_en=1; writes are accepted in any state.
  - Step data is latched at step start. A write to the playing step, or a write on the same cycle as its latch, takes effect on the next visit; the latch reads the pre-write value.
- Effective lengths, computed combinationally and sampled at step start:
  - S = max(step_ticks, 4).
  - G = min(max(gate_ticks, 2), S−2).
  - This gives trig ≥ 2 ticks high and ≥ 2 ticks low per step.
- Prescaler:
  - Counts 0..TICK_DIV−1 while FSM≠IDLE.
  - Emits a tick on the cycle it wraps to 0.
  - Held at 0 in IDLE.
- FSM states: IDLE, GATE, REST.
- IDLE → GATE on the first cycle run=1. On that edge:
  - step_idx=0.
  - osc_count=mem[0].count.
  - trig=mem[0].gate.
  - step_stb=1 for one cycle.
  - tick counter=0.
- GATE: after G ticks from step start, trig←0 and go to REST.
- REST: after S total ticks from step start, a new step starts:
  - step_idx ← (step_idx==last_step) ? 0 : step_idx+1.
  - Load osc_count and trig from the new step's memory.
  - Pulse step_stb.
  - Return to GATE.
- Gate bit 0: trig stays 0 for the whole step. The FSM still walks GATE→REST so timing is identical.
- last_step lowered below the current step_idx: the current step completes, then the sequencer wraps to 0.
- run=0 in GATE or REST, on the next edge:
  - trig←0, FSM→IDLE, step_idx←0, prescaler←0.
  - osc_count holds its last value.
  - A run re-assertion always restarts at step 0.
- Simultaneous run fall and step boundary: stop wins; no step_stb.
- rst mid-operation forces all reset values asynchronously, including memory clear.
- Latency: trig rising edge coincides with step_stb, 1 clk after the tick that ends the previous step (or after run is sampled high).

Decomposition:
- synth_pkg holds:
  - OSC_W=12, STEP_AW=3, MIN_GATE_TICKS=2, MIN_REST_TICKS=2.
  - FSM state enum (IDLE, GATE, REST).
  - 13-bit step record typedef {gate, count}.
- One sub-module: tick_prescaler (TICK_DIV parameter; enable and tick output; clear when disabled). It can later be reused for the synth's own dividers.

Test Plan (TICK_DIV=4 in simulation):
- Reset with run=0 → all outputs 0. Write mem[0]={1,0x123}, mem[1]={1,0x456}, last_step=1, step_ticks=4, gate_ticks=2, then raise run:
  - Next edge: osc_count=0x123, trig=1, step_stb=1.
  - trig falls 8 clks later.
  - Step 1 starts 16 clks after step 0 with osc_count=0x456.
  - Step 2 wraps to step_idx=0.
- gate_ticks=0, step_ticks=1 → clamped: trig high exactly 8 clks, low 8 clks, period 16 clks.
- gate_ticks=200, step_ticks=10 → trig high 32 clks, low 8 clks.
- mem[2] gate=0 with last_step=3 → trig stays 0 for all of step 2; step_stb still pulses; step_idx sequence 0,1,2,3,0.
- Write mem[1]={1,0xABC} during step 1 → osc_count keeps 0x456 for that step and shows 0xABC on the next visit to step 1.
- Drop run mid-GATE → trig=0 next edge, step_idx=0. Re-raise run → restart at step 0 with step_stb. Assert rst asynchronously mid-REST → outputs 0 immediately and memory cleared.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared types and constants for the step sequencer and the synth it feeds.
package synth_pkg;

  localparam int unsigned OSC_W          = 12;
  localparam int unsigned STEP_AW        = 3;
  localparam int unsigned TICK_W         = 8;
  localparam int unsigned MIN_GATE_TICKS = 2;
  localparam int unsigned MIN_REST_TICKS = 2;
  localparam int unsigned MIN_STEP_TICKS = MIN_GATE_TICKS + MIN_REST_TICKS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    REST = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic             gate;
    logic [OSC_W-1:0] count;
  } step_rec_t;

  localparam int unsigned REC_W = $bits(step_rec_t);

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..TICK_DIV-1 divider; tick_c flags the cycle before the wrap to 0.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 262144
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Disabled means cleared, so every enable starts a full tick period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick_c = en && (cnt == CNT_LAST);

endmodule

// File: rtl/step_sequencer.sv
// 8-step pattern sequencer driving the synth's trig and osc_count, timed in prescaled ticks.
module step_sequencer
  import synth_pkg::*;
#(
  parameter int unsigned TICK_DIV = 262144,
  parameter int unsigned STEPS    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               wr_en,
  input  logic [STEP_AW-1:0] wr_addr,
  input  logic [REC_W-1:0]   wr_data,
  input  logic [STEP_AW-1:0] last_step,
  input  logic [TICK_W-1:0]  step_ticks,
  input  logic [TICK_W-1:0]  gate_ticks,
  output logic [OSC_W-1:0]   osc_count,
  output logic               trig,
  output logic [STEP_AW-1:0] step_idx,
  output logic               step_stb
);

  step_rec_t          mem [STEPS];
  seq_state_t         state, state_d;
  logic [TICK_W-1:0]  tcnt, tcnt_d, tcnt_inc;
  logic [TICK_W-1:0]  s_len, s_len_d, g_len, g_len_d;
  logic [TICK_W-1:0]  s_eff, g_floor, g_lim, g_eff;
  logic [STEP_AW-1:0] step_idx_d, start_idx;
  logic [OSC_W-1:0]   osc_d;
  logic               trig_d, stb_d, start, tick_c;
  step_rec_t          rec;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    ((state != IDLE) && run),
    .tick_c(tick_c)
  );

  // Clamp lengths so trig always gets at least two ticks high and two low
  always_comb begin
    s_eff   = (step_ticks < TICK_W'(MIN_STEP_TICKS)) ? TICK_W'(MIN_STEP_TICKS) : step_ticks;
    g_floor = (gate_ticks < TICK_W'(MIN_GATE_TICKS)) ? TICK_W'(MIN_GATE_TICKS) : gate_ticks;
    g_lim   = s_eff - TICK_W'(MIN_REST_TICKS);
    g_eff   = (g_floor > g_lim) ? g_lim : g_floor;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(STEPS); i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && (32'(wr_addr) < STEPS)) begin
      mem[wr_addr] <= step_rec_t'(wr_data);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      step_idx  <= '0;
      osc_count <= '0;
      trig      <= 1'b0;
      step_stb  <= 1'b0;
      tcnt      <= '0;
      s_len     <= TICK_W'(MIN_STEP_TICKS);
      g_len     <= TICK_W'(MIN_GATE_TICKS);
    end else begin
      state     <= state_d;
      step_idx  <= step_idx_d;
      osc_count <= osc_d;
      trig      <= trig_d;
      step_stb  <= stb_d;
      tcnt      <= tcnt_d;
      s_len     <= s_len_d;
      g_len     <= g_len_d;
    end
  end

  // Stop beats any step boundary; a step start reads memory before this edge's write
  always_comb begin
    state_d    = state;
    step_idx_d = step_idx;
    osc_d      = osc_count;
    trig_d     = trig;
    stb_d      = 1'b0;
    tcnt_d     = tcnt;
    s_len_d    = s_len;
    g_len_d    = g_len;
    start      = 1'b0;
    start_idx  = '0;
    rec        = '0;
    tcnt_inc   = tcnt + TICK_W'(1);

    case (state)
      IDLE: begin
        if (run) begin
          start = 1'b1;
        end
      end
      GATE, REST: begin
        if (!run) begin
          state_d    = IDLE;
          trig_d     = 1'b0;
          step_idx_d = '0;
          tcnt_d     = '0;
        end else if (tick_c) begin
          tcnt_d = tcnt_inc;
          if ((state == GATE) && (tcnt_inc == g_len)) begin
            trig_d  = 1'b0;
            state_d = REST;
          end else if ((state == REST) && (tcnt_inc == s_len)) begin
            start     = 1'b1;
            start_idx = (step_idx >= last_step) ? '0 : step_idx + STEP_AW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (start) begin
      if (32'(start_idx) < STEPS) begin
        rec = mem[start_idx];
      end
      state_d    = GATE;
      step_idx_d = start_idx;
      osc_d      = rec.count;
      trig_d     = rec.gate;
      stb_d      = 1'b1;
      tcnt_d     = '0;
      s_len_d    = s_eff;
      g_len_d    = g_eff;
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: clock-count reference model plus directed literal checks.
module tb_step_sequencer;

  localparam int unsigned TD = 4;

  logic        clk, rst, run, wr_en;
  logic [2:0]  wr_addr, last_step;
  logic [12:0] wr_data;
  logic [7:0]  step_ticks, gate_ticks;
  logic [11:0] osc_count;
  logic        trig, step_stb;
  logic [2:0]  step_idx;

  int n_cmp = 0;
  int n_err = 0;

  step_sequencer #(.TICK_DIV(TD), .STEPS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .last_step (last_step),
    .step_ticks(step_ticks),
    .gate_ticks(gate_ticks),
    .osc_count (osc_count),
    .trig      (trig),
    .step_idx  (step_idx),
    .step_stb  (step_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: step timing measured directly in system clocks since step start
  logic [12:0] m_mem [8];
  bit          m_play;
  logic [2:0]  m_idx;
  logic [11:0] m_osc;
  logic        m_trig, m_stb;
  int          m_el, m_s, m_g;

  task automatic m_start(input logic [2:0] i);
    int g;
    m_play = 1'b1;
    m_idx  = i;
    m_osc  = m_mem[i][11:0];
    m_trig = m_mem[i][12];
    m_stb  = 1'b1;
    m_el   = 0;
    m_s    = (step_ticks < 8'd4) ? 4 : int'(step_ticks);
    g      = (gate_ticks < 8'd2) ? 2 : int'(gate_ticks);
    m_g    = (g > m_s - 2) ? m_s - 2 : g;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_play = 1'b0; m_idx = '0; m_osc = '0; m_trig = 1'b0; m_stb = 1'b0; m_el = 0;
      for (int i = 0; i < 8; i++) m_mem[i] = '0;
    end else begin
      m_stb = 1'b0;
      if (!m_play) begin
        if (run) m_start(3'd0);
      end else if (!run) begin
        m_play = 1'b0; m_trig = 1'b0; m_idx = '0;
      end else begin
        m_el++;
        if (m_el == m_g * int'(TD)) m_trig = 1'b0;
        if (m_el == m_s * int'(TD)) m_start((m_idx >= last_step) ? 3'd0 : m_idx + 3'd1);
      end
      if (wr_en) m_mem[wr_addr] = wr_data;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("model_osc", osc_count, m_osc);
      check("model_trig", trig, m_trig);
      check("model_idx", step_idx, m_idx);
      check("model_stb", step_stb, m_stb);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_step(input logic [2:0] a, input logic g, input logic [11:0] c);
    wr_en = 1'b1; wr_addr = a; wr_data = {g, c};
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_stb();
    int n = 0;
    do begin @(negedge clk); n++; end while (!step_stb && n < 200);
    check("wait_stb", step_stb, 1);
  endtask

  task automatic wait_idx(input logic [2:0] t);
    int n = 0;
    do begin wait_stb(); n++; end while (step_idx != t && n < 16);
    check("wait_idx", step_idx, t);
  endtask

  // Called at a step_stb cycle; returns at the next one with trig high/low clock counts
  task automatic run_step(output int idx, output int hi, output int lo);
    int n = 0;
    idx = step_idx; hi = 0; lo = 0;
    do begin
      if (trig) hi++; else lo++;
      @(negedge clk); n++;
    end while (!step_stb && n < 2000);
    check("run_step_end", step_stb, 1);
  endtask

  initial begin
    int ix, hi, lo;
    int exp_idx [5] = '{0, 1, 2, 3, 0};
    int exp_hi  [5] = '{8, 8, 0, 8, 8};
    rst = 1'b0; run = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    last_step = 3'd1; step_ticks = 8'd4; gate_ticks = 8'd2;
    #1 rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("rst_osc", osc_count, 0);
    check("rst_trig", trig, 0);
    check("rst_idx", step_idx, 0);
    check("rst_stb", step_stb, 0);

    write_step(3'd0, 1'b1, 12'h123);
    write_step(3'd1, 1'b1, 12'h456);
    run = 1'b1;
    tick(1);
    check("start_osc", osc_count, 'h123);
    check("start_trig", trig, 1);
    check("start_stb", step_stb, 1);
    tick(1);
    check("stb_one_cycle", step_stb, 0);
    tick(6);
    check("gate_still_high", trig, 1);
    tick(1);
    check("gate_fell_8", trig, 0);
    tick(8);
    check("step1_idx", step_idx, 1);
    check("step1_osc", osc_count, 'h456);
    check("step1_stb", step_stb, 1);
    tick(16);
    check("wrap_idx", step_idx, 0);
    check("wrap_stb", step_stb, 1);

    gate_ticks = 8'd0; step_ticks = 8'd1;
    run_step(ix, hi, lo);
    run_step(ix, hi, lo);
    check("clamp_lo_hi", hi, 8);
    check("clamp_lo_lo", lo, 8);
    gate_ticks = 8'd200; step_ticks = 8'd10;
    run_step(ix, hi, lo);
    run_step(ix, hi, lo);
    check("clamp_hi_hi", hi, 32);
    check("clamp_hi_lo", lo, 8);
    gate_ticks = 8'd2; step_ticks = 8'd4;
    run_step(ix, hi, lo);

    write_step(3'd2, 1'b0, 12'h789);
    write_step(3'd3, 1'b1, 12'h321);
    last_step = 3'd3;
    wait_idx(3'd0);
    for (int i = 0; i < 5; i++) begin
      run_step(ix, hi, lo);
      check("seq_idx", ix, exp_idx[i]);
      check("seq_hi", hi, exp_hi[i]);
    end

    write_step(3'd1, 1'b1, 12'hABC);
    tick(4);
    check("write_playing_hold", osc_count, 'h456);
    wait_idx(3'd1);
    check("write_next_visit", osc_count, 'hABC);

    tick(15);
    run = 1'b0;
    tick(1);
    check("stopwin_stb", step_stb, 0);
    check("stopwin_idx", step_idx, 0);
    check("stopwin_osc_hold", osc_count, 'hABC);
    run = 1'b1;
    tick(1);
    check("restart_stb", step_stb, 1);
    check("restart_osc", osc_count, 'h123);

    wait_idx(3'd1);
    tick(3);
    run = 1'b0;
    tick(1);
    check("stop_gate_trig", trig, 0);
    check("stop_gate_idx", step_idx, 0);
    check("stop_gate_osc", osc_count, 'hABC);
    run = 1'b1;
    tick(1);
    check("rerun_stb", step_stb, 1);
    check("rerun_idx", step_idx, 0);
    check("rerun_trig", trig, 1);

    tick(10);
    check("rest_trig", trig, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_osc", osc_count, 0);
    check("arst_trig", trig, 0);
    check("arst_idx", step_idx, 0);
    check("arst_stb", step_stb, 0);
    run = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    run = 1'b1;
    tick(1);
    check("clr_stb", step_stb, 1);
    check("clr_osc", osc_count, 0);
    check("clr_trig", trig, 0);
    tick(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1);
  end

endmodule
